// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA raster constants and colour types
package vga_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;
    localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    // Colour word packed as {B,G,R}, one byte each
    typedef logic [23:0] bgr_t;

    localparam bgr_t BLACK = 24'h000000;

endpackage

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - raster counters, sync windows and frame strobes
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP
) (
    input  logic       iVGA_CLK,
    input  logic       iRST,
    output logic [9:0] hCount,
    output logic [9:0] vCount,
    output logic       visible,
    output logic       hSync,
    output logic       vSync,
    output logic       frameStart,
    output logic       loadStrobe
);

    localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEGIN = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEGIN = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    // Pixel and line counters; frameStart is the registered (0,0) marker
    always_ff @(posedge iVGA_CLK) begin
        if (iRST) begin
            hCount     <= '0;
            vCount     <= '0;
            frameStart <= 1'b0;
        end else begin
            frameStart <= (hCount == '0) && (vCount == '0);
            if (hCount == H_LAST) begin
                hCount <= '0;
                vCount <= (vCount == V_LAST) ? '0 : vCount + 10'd1;
            end else begin
                hCount <= hCount + 10'd1;
            end
        end
    end

    assign visible    = (hCount < H_ACT) && (vCount < V_ACT);
    assign hSync      = !((hCount >= HS_BEGIN) && (hCount < HS_END));
    assign vSync      = !((vCount >= VS_BEGIN) && (vCount < VS_END));
    assign loadStrobe = (hCount == '0) && (vCount == V_ACT);

endmodule

// File: rtl/vga_sprite_compositor.sv
// rtl/vga_sprite_compositor.sv - background fetch plus fixed-priority sprite overlay
module vga_sprite_compositor
    import vga_pkg::*;
#(
    parameter int N_SPR      = 4,
    parameter int SPR_W      = 32,
    parameter int SPR_H      = 32,
    parameter int SCALE_LOG2 = 1,
    parameter int BG_LAT     = 1,
    parameter int H_ACTIVE   = VGA_H_ACTIVE,
    parameter int H_FP       = VGA_H_FP,
    parameter int H_SYNC     = VGA_H_SYNC,
    parameter int H_BP       = VGA_H_BP,
    parameter int V_ACTIVE   = VGA_V_ACTIVE,
    parameter int V_FP       = VGA_V_FP,
    parameter int V_SYNC     = VGA_V_SYNC,
    parameter int V_BP       = VGA_V_BP
) (
    input  logic                iVGA_CLK,
    input  logic                iRST,
    input  logic [N_SPR*10-1:0] spr_x,
    input  logic [N_SPR*9-1:0]  spr_y,
    input  logic [N_SPR*24-1:0] spr_bgr,
    input  logic [N_SPR-1:0]    spr_en,
    input  logic                blackout,
    output logic [18:0]         bg_addr,
    input  logic [23:0]         bg_bgr,
    output logic                oHS,
    output logic                oVS,
    output logic                oBLANK_n,
    output logic [7:0]          b_data,
    output logic [7:0]          g_data,
    output logic [7:0]          r_data,
    output logic                frame_start
);

    localparam logic [10:0] SPR_W11 = 11'(SPR_W);
    localparam logic [10:0] SPR_H11 = 11'(SPR_H);
    localparam logic [18:0] BG_ROW  = 19'(H_ACTIVE >> SCALE_LOG2);
    localparam int          LAST    = BG_LAT - 1;

    logic [9:0] hCount;
    logic [9:0] vCount;
    logic       visible;
    logic       hSync;
    logic       vSync;
    logic       loadStrobe;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) uTiming (
        .iVGA_CLK   (iVGA_CLK),
        .iRST       (iRST),
        .hCount     (hCount),
        .vCount     (vCount),
        .visible    (visible),
        .hSync      (hSync),
        .vSync      (vSync),
        .frameStart (frame_start),
        .loadStrobe (loadStrobe)
    );

    logic [9:0]       shX   [N_SPR];
    logic [8:0]       shY   [N_SPR];
    bgr_t             shBgr [N_SPR];
    logic [N_SPR-1:0] shEn;

    // Shadow sprite set, refreshed only at the top of vertical blanking so a frame never tears
    always_ff @(posedge iVGA_CLK) begin
        if (iRST) begin
            for (int i = 0; i < N_SPR; i++) begin
                shX[i]   <= '0;
                shY[i]   <= '0;
                shBgr[i] <= BLACK;
            end
            shEn <= '0;
        end else if (loadStrobe) begin
            for (int i = 0; i < N_SPR; i++) begin
                shX[i]   <= spr_x[10*i +: 10];
                shY[i]   <= spr_y[9*i +: 9];
                shBgr[i] <= spr_bgr[24*i +: 24];
            end
            shEn <= spr_en;
        end
    end

    logic [N_SPR-1:0] hitNext;
    logic [18:0]      addrNext;

    // Half-open rectangle test per channel; the extra bit keeps right/bottom edges from wrapping
    always_comb begin
        hitNext = '0;
        for (int i = 0; i < N_SPR; i++) begin
            hitNext[i] = shEn[i]
                && ({1'b0, hCount} >= {1'b0, shX[i]})
                && ({1'b0, hCount} <  ({1'b0, shX[i]} + SPR_W11))
                && ({1'b0, vCount} >= {2'b0, shY[i]})
                && ({1'b0, vCount} <  ({2'b0, shY[i]} + SPR_H11));
        end
    end

    // Background address from the scaled-down raster position, parked at 0 during blanking
    always_comb begin
        addrNext = '0;
        if (visible) begin
            addrNext = 19'(vCount >> SCALE_LOG2) * BG_ROW + 19'(hCount >> SCALE_LOG2);
        end
    end

    logic             s1Vis;
    logic             s1Hs;
    logic             s1Vs;
    logic [N_SPR-1:0] s1Hit;

    // Stage 1: issue the ROM read and capture position-derived state alongside it
    always_ff @(posedge iVGA_CLK) begin
        if (iRST) begin
            s1Vis   <= 1'b0;
            s1Hs    <= 1'b1;
            s1Vs    <= 1'b1;
            s1Hit   <= '0;
            bg_addr <= '0;
        end else begin
            s1Vis   <= visible;
            s1Hs    <= hSync;
            s1Vs    <= vSync;
            s1Hit   <= hitNext;
            bg_addr <= addrNext;
        end
    end

    logic             dVis [BG_LAT];
    logic             dHs  [BG_LAT];
    logic             dVs  [BG_LAT];
    logic [N_SPR-1:0] dHit [BG_LAT];

    // Delay line matching the ROM read latency so hits and syncs line up with bg_bgr
    always_ff @(posedge iVGA_CLK) begin
        if (iRST) begin
            for (int k = 0; k < BG_LAT; k++) begin
                dVis[k] <= 1'b0;
                dHs[k]  <= 1'b1;
                dVs[k]  <= 1'b1;
                dHit[k] <= '0;
            end
        end else begin
            dVis[0] <= s1Vis;
            dHs[0]  <= s1Hs;
            dVs[0]  <= s1Vs;
            dHit[0] <= s1Hit;
            for (int k = 1; k < BG_LAT; k++) begin
                dVis[k] <= dVis[k-1];
                dHs[k]  <= dHs[k-1];
                dVs[k]  <= dVs[k-1];
                dHit[k] <= dHit[k-1];
            end
        end
    end

    bgr_t pixNext;
    bgr_t pixOut;

    // Colour select: blanking wins, then lowest-index sprite, then blackout, then background
    always_comb begin
        pixNext = blackout ? BLACK : bg_bgr;
        for (int i = N_SPR - 1; i >= 0; i--) begin
            if (dHit[LAST][i]) begin
                pixNext = shBgr[i];
            end
        end
        if (!dVis[LAST]) begin
            pixNext = BLACK;
        end
    end

    // Output register drives syncs and colour on the same edge
    always_ff @(posedge iVGA_CLK) begin
        if (iRST) begin
            oHS      <= 1'b1;
            oVS      <= 1'b1;
            oBLANK_n <= 1'b0;
            pixOut   <= BLACK;
        end else begin
            oHS      <= dHs[LAST];
            oVS      <= dVs[LAST];
            oBLANK_n <= dVis[LAST];
            pixOut   <= pixNext;
        end
    end

    assign b_data = pixOut[23:16];
    assign g_data = pixOut[15:8];
    assign r_data = pixOut[7:0];

endmodule

// File: tb/tb_vga_sprite_compositor.sv
// tb/tb_vga_sprite_compositor.sv - directed checks of raster timing, sprites and double buffering
module tb_vga_sprite_compositor;

    localparam int HT = 200;
    localparam int VT = 104;
    localparam int FT = HT * VT;
    localparam int NS = 4;

    localparam logic [23:0] RED   = 24'h0000FF;
    localparam logic [23:0] GREEN = 24'h00FF00;
    localparam logic [23:0] BLUE  = 24'hFF0000;
    localparam logic [23:0] WHITE = 24'hFFFFFF;

    typedef struct {
        int          x;
        int          y;
        logic [23:0] c;
    } pix_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [NS*10-1:0] sprX;
    logic [NS*9-1:0]  sprY;
    logic [NS*24-1:0] sprBgr;
    logic [NS-1:0]    sprEn;
    logic             blackout;
    logic [18:0]      bgAddr;
    logic [23:0]      bgBgr;
    logic             hs;
    logic             vs;
    logic             blankN;
    logic [7:0]       bD;
    logic [7:0]       gD;
    logic [7:0]       rD;
    logic             frameStart;
    logic [23:0]      pix;

    int cyc    = 0;
    int errors = 0;
    int checks = 0;
    int fs0, fs1, fs2, fs3;

    assign pix = {bD, gD, rD};

    vga_sprite_compositor #(
        .N_SPR      (NS),
        .SPR_W      (32),
        .SPR_H      (32),
        .SCALE_LOG2 (1),
        .BG_LAT     (1),
        .H_ACTIVE   (160),
        .H_FP       (8),
        .H_SYNC     (16),
        .H_BP       (16),
        .V_ACTIVE   (96),
        .V_FP       (2),
        .V_SYNC     (2),
        .V_BP       (4)
    ) dut (
        .iVGA_CLK    (clk),
        .iRST        (rst),
        .spr_x       (sprX),
        .spr_y       (sprY),
        .spr_bgr     (sprBgr),
        .spr_en      (sprEn),
        .blackout    (blackout),
        .bg_addr     (bgAddr),
        .bg_bgr      (bgBgr),
        .oHS         (hs),
        .oVS         (vs),
        .oBLANK_n    (blankN),
        .b_data      (bD),
        .g_data      (gD),
        .r_data      (rD),
        .frame_start (frameStart)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [23:0] romFn(input logic [18:0] a);
        return {5'b10101, a};
    endfunction

    always @(posedge clk) bgBgr <= romFn(bgAddr);

    function automatic logic [23:0] expBg(input int x, input int y);
        return romFn(19'((y / 2) * 80 + x / 2));
    endfunction

    task automatic waitCyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic waitFrame(output int fs);
        int n = 0;
        @(negedge clk);
        while (frameStart !== 1'b1 && n < 30000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (frameStart !== 1'b1) begin
            errors++;
            $display("FAIL frame_start_timeout got=%b want=1", frameStart);
        end
        fs = cyc;
    endtask

    task automatic setSprite(input int i, input int x, input int y, input logic [23:0] c, input logic en);
        sprX[i*10 +: 10]   = 10'(x);
        sprY[i*9 +: 9]     = 9'(y);
        sprBgr[i*24 +: 24] = c;
        sprEn[i]           = en;
    endtask

    task automatic test_reset;
        rst = 1'b1; blackout = 1'b0; sprX = '0; sprY = '0; sprBgr = '0; sprEn = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (hs !== 1'b1) begin errors++; $display("FAIL reset_hs got=%b want=1", hs); end
        checks++; if (vs !== 1'b1) begin errors++; $display("FAIL reset_vs got=%b want=1", vs); end
        checks++; if (blankN !== 1'b0) begin errors++; $display("FAIL reset_blank got=%b want=0", blankN); end
        checks++; if (pix !== 24'h0) begin errors++; $display("FAIL reset_rgb got=%h want=000000", pix); end
        checks++; if (bgAddr !== 19'd0) begin errors++; $display("FAIL reset_addr got=%0d want=0", bgAddr); end
        checks++; if (frameStart !== 1'b0) begin errors++; $display("FAIL reset_fs got=%b want=0", frameStart); end
        rst = 1'b0;
        @(negedge clk);
        fs0 = cyc;
        checks++; if (frameStart !== 1'b1) begin errors++; $display("FAIL fs_first got=%b want=1", frameStart); end
        checks++; if (blankN !== 1'b0) begin errors++; $display("FAIL fill1_blank got=%b want=0", blankN); end
        @(negedge clk);
        checks++; if (frameStart !== 1'b0) begin errors++; $display("FAIL fs_pulse got=%b want=0", frameStart); end
        checks++; if (blankN !== 1'b0) begin errors++; $display("FAIL fill2_blank got=%b want=0", blankN); end
        @(negedge clk);
        checks++; if (blankN !== 1'b1) begin errors++; $display("FAIL first_pix_blank got=%b want=1", blankN); end
        checks++; if (pix !== 24'hA80000) begin errors++; $display("FAIL first_pix_rgb got=%h want=a80000", pix); end
        checks++; if (hs !== 1'b1) begin errors++; $display("FAIL first_pix_hs got=%b want=1", hs); end
    endtask

    task automatic configSprites;
        setSprite(0, 100, 50, RED, 1'b1);
        setSprite(1, 140, 10, BLUE, 1'b1);
        setSprite(2, 120, 70, GREEN, 1'b1);
        setSprite(3, 0, 0, WHITE, 1'b0);
    endtask

    task automatic test_timing;
        int hsLow = 0, hsFirst = -1, act0 = 0, vsLow = 0, vsFirst = -1, actAll = 0;
        int fsCount = 0, fsAt = -1, fall0 = -1, fall1 = -1;
        logic prevHs = 1'b1;
        waitCyc(fs0 + 2);
        for (int k = 0; k < FT; k++) begin
            int x = k % HT;
            int y = k / HT;
            if (y == 0 && !hs) begin
                if (hsFirst < 0) hsFirst = x;
                hsLow++;
            end
            if (prevHs && !hs) begin
                if (fall0 < 0) fall0 = k;
                else if (fall1 < 0) fall1 = k;
            end
            prevHs = hs;
            if (y == 0 && blankN) act0++;
            if (blankN) actAll++;
            if (x == 0 && !vs) begin
                if (vsFirst < 0) vsFirst = y;
                vsLow++;
            end
            if (frameStart) begin
                fsCount++;
                fsAt = cyc;
            end
            @(negedge clk);
        end
        fs1 = fsAt;
        checks++; if (fall1 - fall0 != 200) begin errors++; $display("FAIL line_period got=%0d want=200", fall1 - fall0); end
        checks++; if (hsFirst != 168) begin errors++; $display("FAIL hs_start got=%0d want=168", hsFirst); end
        checks++; if (hsLow != 16) begin errors++; $display("FAIL hs_width got=%0d want=16", hsLow); end
        checks++; if (act0 != 160) begin errors++; $display("FAIL active_per_line got=%0d want=160", act0); end
        checks++; if (vsFirst != 98) begin errors++; $display("FAIL vs_start got=%0d want=98", vsFirst); end
        checks++; if (vsLow != 2) begin errors++; $display("FAIL vs_width got=%0d want=2", vsLow); end
        checks++; if (actAll != 15360) begin errors++; $display("FAIL active_per_frame got=%0d want=15360", actAll); end
        checks++; if (fsCount != 1) begin errors++; $display("FAIL fs_count got=%0d want=1", fsCount); end
        checks++; if (fsAt - fs0 != FT) begin errors++; $display("FAIL frame_period got=%0d want=%0d", fsAt - fs0, FT); end
    endtask

    task automatic test_scale_addr;
        waitCyc(fs1 + 2);
        checks++; if (pix !== 24'hA80000) begin errors++; $display("FAIL disabled_spr got=%h want=a80000", pix); end
        waitCyc(fs1 + 5 * HT + 3);
        checks++; if (bgAddr !== 19'd161) begin errors++; $display("FAIL addr_3_5 got=%0d want=161", bgAddr); end
        waitCyc(fs1 + 5 * HT + 170);
        checks++; if (bgAddr !== 19'd0) begin errors++; $display("FAIL addr_blank got=%0d want=0", bgAddr); end
    endtask

    task automatic test_clipping;
        pix_t tbl [5];
        tbl[0] = '{139, 10, expBg(139, 10)};
        tbl[1] = '{140, 10, BLUE};
        tbl[2] = '{159, 10, BLUE};
        tbl[3] = '{160, 10, 24'h000000};
        tbl[4] = '{0, 11, expBg(0, 11)};
        foreach (tbl[n]) begin
            waitCyc(fs1 + 2 + tbl[n].y * HT + tbl[n].x);
            checks++;
            if (pix !== tbl[n].c) begin
                errors++;
                $display("FAIL clip(%0d,%0d) got=%h want=%h", tbl[n].x, tbl[n].y, pix, tbl[n].c);
            end
        end
    endtask

    task automatic test_double_buffer_update;
        waitCyc(fs1 + 48 * HT);
        setSprite(0, 40, 50, RED, 1'b1);
    endtask

    task automatic test_sprite_boundary;
        pix_t tbl [5];
        tbl[0] = '{99, 50, expBg(99, 50)};
        tbl[1] = '{100, 50, RED};
        tbl[2] = '{132, 50, expBg(132, 50)};
        tbl[3] = '{40, 60, expBg(40, 60)};
        tbl[4] = '{100, 60, RED};
        foreach (tbl[n]) begin
            waitCyc(fs1 + 2 + tbl[n].y * HT + tbl[n].x);
            checks++;
            if (pix !== tbl[n].c) begin
                errors++;
                $display("FAIL bound(%0d,%0d) got=%h want=%h", tbl[n].x, tbl[n].y, pix, tbl[n].c);
            end
        end
    endtask

    task automatic test_priority;
        pix_t tbl [4];
        tbl[0] = '{125, 75, RED};
        tbl[1] = '{131, 81, RED};
        tbl[2] = '{100, 82, expBg(100, 82)};
        tbl[3] = '{140, 90, GREEN};
        foreach (tbl[n]) begin
            waitCyc(fs1 + 2 + tbl[n].y * HT + tbl[n].x);
            checks++;
            if (pix !== tbl[n].c) begin
                errors++;
                $display("FAIL prio(%0d,%0d) got=%h want=%h", tbl[n].x, tbl[n].y, pix, tbl[n].c);
            end
        end
    endtask

    task automatic test_double_buffer_next;
        waitFrame(fs2);
        checks++; if (fs2 - fs1 != FT) begin errors++; $display("FAIL frame_period2 got=%0d want=%0d", fs2 - fs1, FT); end
        waitCyc(fs2 + 2 + 60 * HT + 40);
        checks++; if (pix !== RED) begin errors++; $display("FAIL dbuf_new got=%h want=%h", pix, RED); end
        waitCyc(fs2 + 2 + 60 * HT + 100);
        checks++; if (pix !== expBg(100, 60)) begin errors++; $display("FAIL dbuf_old got=%h want=%h", pix, expBg(100, 60)); end
    endtask

    task automatic test_blackout;
        waitCyc(fs2 + 85 * HT);
        blackout = 1'b1;
        waitCyc(fs2 + 2 + 90 * HT + 10);
        checks++; if (pix !== 24'h0) begin errors++; $display("FAIL blackout_rgb got=%h want=000000", pix); end
        checks++; if (blankN !== 1'b1) begin errors++; $display("FAIL blackout_blank got=%b want=1", blankN); end
        waitCyc(fs2 + 2 + 90 * HT + 140);
        checks++; if (pix !== GREEN) begin errors++; $display("FAIL blackout_spr got=%h want=%h", pix, GREEN); end
    endtask

    task automatic test_mid_reset;
        waitCyc(fs2 + 2 + 92 * HT);
        blackout = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++; if (blankN !== 1'b0) begin errors++; $display("FAIL midrst_blank got=%b want=0", blankN); end
        checks++; if (bgAddr !== 19'd0) begin errors++; $display("FAIL midrst_addr got=%0d want=0", bgAddr); end
        checks++; if (pix !== 24'h0) begin errors++; $display("FAIL midrst_rgb got=%h want=000000", pix); end
        rst = 1'b0;
        @(negedge clk);
        fs3 = cyc;
        checks++; if (frameStart !== 1'b1) begin errors++; $display("FAIL midrst_fs got=%b want=1", frameStart); end
        waitCyc(fs3 + 2 + 10 * HT + 140);
        checks++; if (pix !== expBg(140, 10)) begin errors++; $display("FAIL midrst_shadow got=%h want=%h", pix, expBg(140, 10)); end
        checks++; if (blankN !== 1'b1) begin errors++; $display("FAIL midrst_vis got=%b want=1", blankN); end
    endtask

    initial begin
        test_reset;
        configSprites;
        test_timing;
        test_scale_addr;
        test_clipping;
        test_double_buffer_update;
        test_sprite_boundary;
        test_priority;
        test_double_buffer_next;
        test_blackout;
        test_mid_reset;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
